bp_cce_hybrid_mem_cmd_arbiter: RTL and testbench

Memory command arbiter for the hybrid CCE, directly downstream of the LCE response pipe. It merges two BedRock stream sources onto the single CCE-MEM command output. Source 0 is the LCE response pipe writeback stream; source 1 is the request/coherence pipe command stream. For every memory command it issues the pending-bit increment, and it bounds the number of outstanding memory commands with a credit counter.

---
 rtl/bp_cce_hybrid_mem_cmd_arbiter_pkg.sv | 49 ++++
 rtl/bp_cce_hybrid_mem_cmd_arbiter_credit_counter.sv | 41 ++++
 rtl/bp_cce_hybrid_mem_cmd_arbiter.sv | 118 +++++++++++
 tb/tb_bp_cce_hybrid_mem_cmd_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_hybrid_mem_cmd_arbiter_pkg.sv
// Shared types for the hybrid CCE memory command arbiter: BedRock memory header,
// arbiter FSM states and the credit counter width helper.
package bp_cce_hybrid_mem_cmd_arbiter_pkg;

   localparam int paddr_width_gp     = 40;
   localparam int lce_id_width_gp    = 4;
   localparam int lce_assoc_width_gp = 3;
   localparam int dword_width_gp     = 64;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'b0000,
      e_bedrock_mem_wr    = 4'b0001,
      e_bedrock_mem_uc_rd = 4'b0010,
      e_bedrock_mem_uc_wr = 4'b0011
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1  = 3'b000,
      e_bedrock_msg_size_2  = 3'b001,
      e_bedrock_msg_size_4  = 3'b010,
      e_bedrock_msg_size_8  = 3'b011,
      e_bedrock_msg_size_16 = 3'b100,
      e_bedrock_msg_size_32 = 3'b101,
      e_bedrock_msg_size_64 = 3'b110
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [lce_id_width_gp-1:0]    lce_id;
      logic [lce_assoc_width_gp-1:0] way_id;
   } bp_cce_mem_payload_s;

   typedef struct packed {
      bp_cce_mem_payload_s         payload;
      bp_bedrock_msg_size_e        size;
      logic [paddr_width_gp-1:0]   addr;
      bp_bedrock_mem_type_e        msg_type;
   } bp_cce_mem_msg_header_s;

   typedef enum logic [1:0] {
      e_arb_idle   = 2'b00,
      e_arb_pend   = 2'b01,
      e_arb_stream = 2'b10
   } bp_cce_hybrid_mem_arb_state_e;

   function automatic int credit_width(input int credits);
      return $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/bp_cce_hybrid_mem_cmd_arbiter_credit_counter.sv
// Up/down saturating credit counter that starts full; flags empty (zero) and full.
module bp_cce_hybrid_credit_counter
   import bp_cce_hybrid_mem_cmd_arbiter_pkg::*;
   #(parameter int max_p = 8)
   (input  logic clk_i
   ,input  logic reset_n_i
   ,input  logic up_i
   ,input  logic down_i
   ,output logic zero_o
   ,output logic full_o
   );

   localparam int width_lp = credit_width(max_p);

   logic [width_lp-1:0] count_q, count_d;

   assign zero_o = (count_q == '0);
   assign full_o = (count_q == width_lp'(max_p));

   // Simultaneous up and down cancel; each direction saturates at its bound.
   always_comb begin
      count_d = count_q;
      if (up_i && !down_i && !full_o) begin
         count_d = count_q + width_lp'(1);
      end else if (down_i && !up_i && !zero_o) begin
         count_d = count_q - width_lp'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         count_q <= width_lp'(max_p);
      end else begin
         count_q <= count_d;
      end
   end

   overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(up_i && !down_i && full_o));

endmodule

// File: rtl/bp_cce_hybrid_mem_cmd_arbiter.sv
// Merges the writeback stream (source 0) and request stream (source 1) onto the
// CCE-MEM command port, issuing a pending-bit increment and spending one credit per command.
module bp_cce_hybrid_mem_cmd_arbiter
   import bp_cce_hybrid_mem_cmd_arbiter_pkg::*;
   #(parameter int mem_data_width_p = dword_width_gp
   ,parameter int mem_credits_p     = 8)
   (input  logic                                     clk_i
   ,input  logic                                     reset_n_i
   ,input  bp_cce_mem_msg_header_s [1:0]             src_header_i
   ,input  logic [1:0][mem_data_width_p-1:0]         src_data_i
   ,input  logic [1:0]                               src_v_i
   ,input  logic [1:0]                               src_last_i
   ,output logic [1:0]                               src_ready_and_o
   ,output bp_cce_mem_msg_header_s                   mem_cmd_header_o
   ,output logic [mem_data_width_p-1:0]              mem_cmd_data_o
   ,output logic                                     mem_cmd_v_o
   ,output logic                                     mem_cmd_last_o
   ,input  logic                                     mem_cmd_ready_and_i
   ,output logic                                     pending_w_v_o
   ,input  logic                                     pending_w_yumi_i
   ,output logic [paddr_width_gp-1:0]                pending_w_addr_o
   ,output logic                                     pending_w_addr_bypass_hash_o
   ,output logic                                     pending_up_o
   ,output logic                                     pending_down_o
   ,output logic                                     pending_clear_o
   ,input  logic                                     mem_credit_return_i
   ,output logic                                     empty_o
   );

   bp_cce_hybrid_mem_arb_state_e state_q, state_d;
   logic grant_q, grant_d;
   logic rr_pri_q, rr_pri_d;
   logic first_q, first_d;
   logic credits_zero, credits_full;
   logic stream_active, beat_hs, credit_down;

   // Gating with reset keeps a beat from completing in the cycle reset is sampled.
   assign stream_active = reset_n_i & (state_q == e_arb_stream);

   assign mem_cmd_header_o = src_header_i[grant_q];
   assign mem_cmd_data_o   = src_data_i[grant_q];
   assign mem_cmd_last_o   = src_last_i[grant_q];
   assign mem_cmd_v_o      = stream_active & src_v_i[grant_q];
   assign beat_hs          = mem_cmd_v_o & mem_cmd_ready_and_i;
   assign credit_down      = beat_hs & first_q;

   always_comb begin
      src_ready_and_o          = '0;
      src_ready_and_o[grant_q] = stream_active & mem_cmd_ready_and_i;
   end

   assign pending_w_v_o                = reset_n_i & (state_q == e_arb_pend);
   assign pending_w_addr_o             = src_header_i[grant_q].addr;
   assign pending_w_addr_bypass_hash_o = 1'b0;
   assign pending_up_o                 = 1'b1;
   assign pending_down_o               = 1'b0;
   assign pending_clear_o              = 1'b0;

   assign empty_o = (state_q == e_arb_idle) & ~|src_v_i & credits_full;

   // The granted source stays locked until its last beat handshakes.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_pri_d = rr_pri_q;
      first_d  = first_q;
      case (state_q)
         e_arb_idle: begin
            if (!credits_zero && |src_v_i) begin
               grant_d = (&src_v_i) ? rr_pri_q : src_v_i[1];
               state_d = e_arb_pend;
            end
         end
         e_arb_pend: begin
            if (pending_w_yumi_i) begin
               first_d = 1'b1;
               state_d = e_arb_stream;
            end
         end
         e_arb_stream: begin
            if (beat_hs) begin
               first_d = 1'b0;
               if (mem_cmd_last_o) begin
                  rr_pri_d = ~grant_q;
                  state_d  = e_arb_idle;
               end
            end
         end
         default: state_d = e_arb_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q  <= e_arb_idle;
         grant_q  <= 1'b0;
         rr_pri_q <= 1'b0;
         first_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_pri_q <= rr_pri_d;
         first_q  <= first_d;
      end
   end

   bp_cce_hybrid_credit_counter
      #(.max_p(mem_credits_p))
      credit_counter
      (.clk_i     (clk_i)
      ,.reset_n_i (reset_n_i)
      ,.up_i      (mem_credit_return_i)
      ,.down_i    (credit_down)
      ,.zero_o    (credits_zero)
      ,.full_o    (credits_full)
      );

endmodule

// File: tb/tb_bp_cce_hybrid_mem_cmd_arbiter.sv
// Directed bench for the hybrid CCE memory command arbiter: a per-cycle vector
// table plus hand-written round-robin, credit and reset sequences.
module tb_bp_cce_hybrid_mem_cmd_arbiter;
   import bp_cce_hybrid_mem_cmd_arbiter_pkg::*;

   logic clk_i = 1'b0;
   logic reset_n_i;
   bp_cce_mem_msg_header_s [1:0] src_header_i;
   logic [1:0][63:0] src_data_i;
   logic [1:0] src_v_i, src_last_i, src_ready_and_o;
   bp_cce_mem_msg_header_s mem_cmd_header_o;
   logic [63:0] mem_cmd_data_o;
   logic mem_cmd_v_o, mem_cmd_last_o, mem_cmd_ready_and_i;
   logic pending_w_v_o, pending_w_yumi_i;
   logic [paddr_width_gp-1:0] pending_w_addr_o;
   logic pending_w_addr_bypass_hash_o, pending_up_o, pending_down_o, pending_clear_o;
   logic mem_credit_return_i, empty_o;
   logic [3:0] credits_obs;

   int checks = 0;
   int errors = 0;

   localparam logic [39:0] addr0_c = 40'h00_8000_0040;
   localparam logic [39:0] addr1_c = 40'h00_8000_1000;
   localparam logic [63:0] d1_c    = 64'hC1;

   always #5 clk_i = ~clk_i;

   assign credits_obs = dut.credit_counter.count_q;

   bp_cce_hybrid_mem_cmd_arbiter #(.mem_data_width_p(64), .mem_credits_p(8)) dut
      (.clk_i                        (clk_i)
      ,.reset_n_i                    (reset_n_i)
      ,.src_header_i                 (src_header_i)
      ,.src_data_i                   (src_data_i)
      ,.src_v_i                      (src_v_i)
      ,.src_last_i                   (src_last_i)
      ,.src_ready_and_o              (src_ready_and_o)
      ,.mem_cmd_header_o             (mem_cmd_header_o)
      ,.mem_cmd_data_o               (mem_cmd_data_o)
      ,.mem_cmd_v_o                  (mem_cmd_v_o)
      ,.mem_cmd_last_o               (mem_cmd_last_o)
      ,.mem_cmd_ready_and_i          (mem_cmd_ready_and_i)
      ,.pending_w_v_o                (pending_w_v_o)
      ,.pending_w_yumi_i             (pending_w_yumi_i)
      ,.pending_w_addr_o             (pending_w_addr_o)
      ,.pending_w_addr_bypass_hash_o (pending_w_addr_bypass_hash_o)
      ,.pending_up_o                 (pending_up_o)
      ,.pending_down_o               (pending_down_o)
      ,.pending_clear_o              (pending_clear_o)
      ,.mem_credit_return_i          (mem_credit_return_i)
      ,.empty_o                      (empty_o)
      );

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  last;
      logic [63:0] d0;
      logic        rdy;
      logic        yumi;
      logic        ret;
      logic        mv;
      logic        ml;
      logic [63:0] md;
      logic        pv;
      logic [39:0] pa;
      logic [1:0]  srdy;
      logic        empty;
      int          cr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [1:0] v, logic [1:0] last, logic [63:0] d0,
                               logic rdy, logic yumi, logic ret,
                               logic mv, logic ml, logic [63:0] md, logic pv,
                               logic [39:0] pa, logic [1:0] srdy, logic empty, int cr);
      vec_t r;
      r.v = v; r.last = last; r.d0 = d0; r.rdy = rdy; r.yumi = yumi; r.ret = ret;
      r.mv = mv; r.ml = ml; r.md = md; r.pv = pv; r.pa = pa; r.srdy = srdy;
      r.empty = empty; r.cr = cr;
      return r;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      src_v_i             = '0;
      src_last_i          = '0;
      src_data_i          = '0;
      mem_cmd_ready_and_i = 1'b1;
      pending_w_yumi_i    = 1'b0;
      mem_credit_return_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;
   endtask

   task automatic apply_stimulus(input vec_t r);
      src_v_i             = r.v;
      src_last_i          = r.last;
      src_data_i[0]       = r.d0;
      src_data_i[1]       = d1_c;
      mem_cmd_ready_and_i = r.rdy;
      pending_w_yumi_i    = r.yumi;
      mem_credit_return_i = r.ret;
   endtask

   // Drives one single-beat message from source s; yumi follows pending valid.
   task automatic send_cmd(input int s, input logic [63:0] data, input bit ret_first);
      bit pend_seen = 1'b0;
      bit done = 1'b0;
      logic [1:0] exp_rdy;
      exp_rdy = '0;
      exp_rdy[s] = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         src_v_i             = '0;
         src_v_i[s]          = 1'b1;
         src_last_i          = 2'b11;
         src_data_i[s]       = data;
         mem_cmd_ready_and_i = 1'b1;
         pending_w_yumi_i    = 1'b0;
         mem_credit_return_i = 1'b0;
         #1;
         if (pending_w_v_o) begin
            pending_w_yumi_i = 1'b1;
            pend_seen = 1'b1;
            check_output("send_pend_up", pending_up_o, 1);
            check_output("send_pend_addr", pending_w_addr_o, src_header_i[s].addr);
         end
         if (mem_cmd_v_o) begin
            mem_credit_return_i = ret_first;
            check_output("send_pend_before_beat", pend_seen, 1);
            check_output("send_data", mem_cmd_data_o, data);
            check_output("send_src_ready", src_ready_and_o, exp_rdy);
            done = 1'b1;
         end
         next_cycle();
      end
      idle_inputs();
      check_output("send_timeout", done, 1);
   endtask

   initial begin
      logic [63:0] rr_exp [4];
      int rem0, rem1, n, pend_cnt;

      src_header_i = '0;
      src_header_i[0].addr     = addr0_c;
      src_header_i[0].msg_type = e_bedrock_mem_wr;
      src_header_i[1].addr     = addr1_c;
      src_header_i[1].msg_type = e_bedrock_mem_rd;

      // Single 8-beat writeback from source 0.
      vecs.push_back(mk(2'b01, 2'b00, 64'h0, 1, 0, 0, 0, 0, 64'h0, 0, addr0_c, 2'b00, 0, 8));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(2'b01, 2'b00, 64'h0, 1, (k == 2), 0, 0, 0, 64'h0, 1, addr0_c, 2'b00, 0, 8));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(2'b01, {1'b0, (i == 7)}, 64'hA0 + 64'(i), 1, 0, 0,
                           1, (i == 7), 64'hA0 + 64'(i), 0, addr0_c, 2'b01, 0, (i == 0) ? 8 : 7));
      vecs.push_back(mk(2'b00, 2'b00, 64'h0, 1, 0, 1, 0, 0, 64'h0, 0, addr0_c, 2'b00, 0, 7));
      vecs.push_back(mk(2'b00, 2'b00, 64'h0, 1, 0, 0, 0, 0, 64'h0, 0, addr0_c, 2'b00, 1, 8));
      // Backpressure on beat 4 with source 1 valid and locked out, then source 1 served.
      vecs.push_back(mk(2'b01, 2'b00, 64'h0, 1, 0, 0, 0, 0, 64'h0, 0, addr0_c, 2'b00, 0, 8));
      vecs.push_back(mk(2'b01, 2'b00, 64'h0, 1, 1, 0, 0, 0, 64'h0, 1, addr0_c, 2'b00, 0, 8));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(2'b11, 2'b10, 64'hB0 + 64'(i), 1, 0, 0,
                           1, 0, 64'hB0 + 64'(i), 0, addr0_c, 2'b01, 0, (i == 0) ? 8 : 7));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(2'b11, 2'b10, 64'hB3, 0, 0, 0, 1, 0, 64'hB3, 0, addr0_c, 2'b00, 0, 7));
      for (int i = 3; i < 8; i++)
         vecs.push_back(mk(2'b11, {1'b1, (i == 7)}, 64'hB0 + 64'(i), 1, 0, 0,
                           1, (i == 7), 64'hB0 + 64'(i), 0, addr0_c, 2'b01, 0, 7));
      vecs.push_back(mk(2'b10, 2'b10, 64'h0, 1, 0, 0, 0, 0, 64'h0, 0, addr1_c, 2'b00, 0, 7));
      vecs.push_back(mk(2'b10, 2'b10, 64'h0, 1, 1, 0, 0, 0, 64'h0, 1, addr1_c, 2'b00, 0, 7));
      vecs.push_back(mk(2'b10, 2'b10, 64'h0, 1, 0, 0, 1, 1, d1_c, 0, addr1_c, 2'b10, 0, 7));
      vecs.push_back(mk(2'b00, 2'b00, 64'h0, 1, 0, 0, 0, 0, 64'h0, 0, addr1_c, 2'b00, 0, 6));

      do_reset();
      #1;
      check_output("reset_pend_v", pending_w_v_o, 0);
      check_output("reset_mem_v", mem_cmd_v_o, 0);
      check_output("reset_src_ready", src_ready_and_o, 0);
      check_output("reset_empty", empty_o, 1);
      check_output("reset_credits", credits_obs, 8);
      check_output("const_bypass_hash", pending_w_addr_bypass_hash_o, 0);
      check_output("const_up", pending_up_o, 1);
      check_output("const_down", pending_down_o, 0);
      check_output("const_clear", pending_clear_o, 0);
      next_cycle();

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         #1;
         check_output($sformatf("vec%0d_mem_v", i), mem_cmd_v_o, vecs[i].mv);
         if (vecs[i].mv) begin
            check_output($sformatf("vec%0d_mem_last", i), mem_cmd_last_o, vecs[i].ml);
            check_output($sformatf("vec%0d_mem_data", i), mem_cmd_data_o, vecs[i].md);
            check_output($sformatf("vec%0d_mem_addr", i), mem_cmd_header_o.addr, vecs[i].pa);
         end
         check_output($sformatf("vec%0d_pend_v", i), pending_w_v_o, vecs[i].pv);
         if (vecs[i].pv)
            check_output($sformatf("vec%0d_pend_addr", i), pending_w_addr_o, vecs[i].pa);
         check_output($sformatf("vec%0d_src_ready", i), src_ready_and_o, vecs[i].srdy);
         check_output($sformatf("vec%0d_empty", i), empty_o, vecs[i].empty);
         check_output($sformatf("vec%0d_credits", i), credits_obs, vecs[i].cr);
         next_cycle();
      end

      // Round robin: both sources valid together, two single-beat commands each.
      do_reset();
      rr_exp = '{64'h500, 64'h600, 64'h501, 64'h601};
      rem0 = 2; rem1 = 2; n = 0; pend_cnt = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         src_v_i             = {(rem1 > 0), (rem0 > 0)};
         src_last_i          = 2'b11;
         src_data_i[0]       = 64'h500 + 64'(2 - rem0);
         src_data_i[1]       = 64'h600 + 64'(2 - rem1);
         mem_cmd_ready_and_i = 1'b1;
         pending_w_yumi_i    = 1'b0;
         #1;
         if (pending_w_v_o) begin
            pending_w_yumi_i = 1'b1;
            pend_cnt++;
            check_output("rr_pend_up", pending_up_o, 1);
         end
         if (mem_cmd_v_o) begin
            check_output("rr_order", mem_cmd_data_o, rr_exp[n]);
            check_output("rr_pend_count", pend_cnt, n + 1);
            if (src_ready_and_o[0]) rem0--;
            else if (src_ready_and_o[1]) rem1--;
            n++;
         end
         next_cycle();
      end
      idle_inputs();
      check_output("rr_all_done", n, 4);
      check_output("rr_credits", credits_obs, 4);

      // Return alone, then return coinciding with a first-beat handshake.
      mem_credit_return_i = 1'b1;
      next_cycle();
      mem_credit_return_i = 1'b0;
      #1;
      check_output("ret_alone_credits", credits_obs, 5);
      send_cmd(0, 64'h700, 1);
      #1;
      check_output("same_cycle_credits", credits_obs, 5);

      // Credit exhaustion: ninth command waits in IDLE until a return.
      do_reset();
      for (int k = 0; k < 8; k++) send_cmd(1, 64'h800 + 64'(k), 0);
      #1;
      check_output("exhaust_credits", credits_obs, 0);
      for (int k = 0; k < 4; k++) begin
         src_v_i = 2'b10; src_last_i = 2'b10; src_data_i[1] = 64'h8FF;
         #1;
         check_output("exhaust_pend_v", pending_w_v_o, 0);
         check_output("exhaust_src_ready", src_ready_and_o, 0);
         check_output("exhaust_mem_v", mem_cmd_v_o, 0);
         next_cycle();
      end
      mem_credit_return_i = 1'b1;
      #1;
      check_output("exhaust_ret_pend_v", pending_w_v_o, 0);
      next_cycle();
      mem_credit_return_i = 1'b0;
      #1;
      check_output("exhaust_grant_cycle_pend_v", pending_w_v_o, 0);
      check_output("exhaust_grant_credits", credits_obs, 1);
      next_cycle();
      #1;
      check_output("exhaust_granted_pend_v", pending_w_v_o, 1);
      send_cmd(1, 64'h8FF, 0);
      #1;
      check_output("exhaust_final_credits", credits_obs, 0);

      // Reset asserted during beat 3 of a source 0 message.
      do_reset();
      src_v_i = 2'b01; src_last_i = 2'b00; src_data_i[0] = 64'h900;
      next_cycle();
      pending_w_yumi_i = 1'b1;
      next_cycle();
      pending_w_yumi_i = 1'b0;
      #1;
      check_output("midreset_beat0_v", mem_cmd_v_o, 1);
      next_cycle();
      src_data_i[0] = 64'h901;
      next_cycle();
      src_data_i[0] = 64'h902;
      reset_n_i = 1'b0;
      #1;
      check_output("midreset_beat_blocked", mem_cmd_v_o, 0);
      check_output("midreset_ready_blocked", src_ready_and_o, 0);
      next_cycle();
      reset_n_i = 1'b1;
      #1;
      check_output("midreset_mem_v", mem_cmd_v_o, 0);
      check_output("midreset_pend_v", pending_w_v_o, 0);
      check_output("midreset_src_ready", src_ready_and_o, 0);
      check_output("midreset_credits", credits_obs, 8);
      src_v_i = 2'b00;
      #1;
      check_output("midreset_empty", empty_o, 1);
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
